// File: rtl/gray_sobel_pkg.sv
// Shared widths, pixel type and small arithmetic helpers for the grey/Sobel edge stage.
package gray_sobel_pkg;

   localparam int PIX_W      = 12;
   localparam int GRAY_SUM_W = 14;
   localparam int GRAD_W     = 15;
   localparam int MAG_W      = 15;
   localparam logic [PIX_W-1:0] PIX_MAX = 12'hFFF;

   typedef logic [PIX_W-1:0] pix_t;

   // a + 2b + c on 12-bit inputs never exceeds 4*4095, so 14 bits suffice.
   function automatic logic [GRAY_SUM_W-1:0] weighted_sum(input pix_t a, input pix_t b, input pix_t c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic pix_t rgb_to_gray(input pix_t r, input pix_t g, input pix_t b);
      logic [GRAY_SUM_W-1:0] s;
      s = weighted_sum(r, g, b);
      return s[GRAY_SUM_W-1:2];
   endfunction

   function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
      logic [GRAD_W-1:0] n;
      n = $unsigned(-g);
      return g[GRAD_W-1] ? n : $unsigned(g);
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two chained line memories giving the row-1 and row-2 taps at the current column.
module sobel_line_buf
   import gray_sobel_pkg::*;
#(
   parameter  int DEPTH = 640,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pix_t          din,
   output pix_t          tap1,
   output pix_t          tap2
);

   pix_t line1 [DEPTH];
   pix_t line2 [DEPTH];

   // Taps read asynchronously so the old contents are seen in the same cycle the write lands.
   assign tap1 = line1[addr];
   assign tap2 = line2[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         line1[addr] <= din;
         line2[addr] <= line1[addr];
      end
   end

endmodule

// File: rtl/gray_sobel.sv
// Grey conversion followed by a 3x3 Sobel magnitude; three-cycle fixed-latency pixel stream.
module gray_sobel
   import gray_sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int MAG_SHIFT  = 0
) (
   input  logic p_clk,
   input  logic rst_n,
   input  logic i_data_val,
   input  pix_t i_red,
   input  pix_t i_green,
   input  pix_t i_blue,
   output pix_t oRed,
   output pix_t oGreen,
   output pix_t oBlue,
   output logic o_data_val
);

   // Valid-only stream: a pixel transfers on every cycle with i_data_val=1, there is no ready;
   // o_data_val=1 marks a result exactly three cycles later, and the outputs hold otherwise.

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   logic             s0_val;
   logic             s0_border;
   logic [COL_W-1:0] s0_col;
   pix_t             s0_gray;

   logic             s1_val;
   logic             s1_border;
   pix_t             win [3][3];   // win[row][col]: row 0 = r-2, row 2 = r; col 0 = c-2, col 2 = c

   pix_t             tap1;
   pix_t             tap2;
   pix_t             edge_q;

   logic signed [GRAD_W-1:0] gx;
   logic signed [GRAD_W-1:0] gy;
   logic        [MAG_W-1:0]  mag;
   logic        [MAG_W-1:0]  mag_sh;
   pix_t                     mag_sat;

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (i_data_val) begin
         if (col == COL_W'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_val    <= 1'b0;
         s0_border <= 1'b0;
         s0_col    <= '0;
         s0_gray   <= '0;
      end else begin
         s0_val <= i_data_val;
         if (i_data_val) begin
            s0_border <= (col < COL_W'(2)) || (row < ROW_W'(2));
            s0_col    <= col;
            s0_gray   <= rgb_to_gray(i_red, i_green, i_blue);
         end
      end
   end

   sobel_line_buf #(.DEPTH(IMG_WIDTH)) u_line_buf (
      .clk  (p_clk),
      .we   (s0_val),
      .addr (s0_col),
      .din  (s0_gray),
      .tap1 (tap1),
      .tap2 (tap2)
   );

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_val    <= 1'b0;
         s1_border <= 1'b0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win[i][j] <= '0;
      end else begin
         s1_val <= s0_val;
         if (s0_val) begin
            s1_border <= s0_border;
            for (int i = 0; i < 3; i++) begin
               win[i][0] <= win[i][1];
               win[i][1] <= win[i][2];
            end
            win[0][2] <= tap2;
            win[1][2] <= tap1;
            win[2][2] <= s0_gray;
         end
      end
   end

   always_comb begin
      gx = $signed({1'b0, weighted_sum(win[0][2], win[1][2], win[2][2])})
         - $signed({1'b0, weighted_sum(win[0][0], win[1][0], win[2][0])});
      gy = $signed({1'b0, weighted_sum(win[2][0], win[2][1], win[2][2])})
         - $signed({1'b0, weighted_sum(win[0][0], win[0][1], win[0][2])});
      mag     = abs_grad(gx) + abs_grad(gy);
      mag_sh  = mag >> MAG_SHIFT;
      mag_sat = (mag_sh > MAG_W'(PIX_MAX)) ? PIX_MAX : mag_sh[PIX_W-1:0];
   end

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data_val <= 1'b0;
         edge_q     <= '0;
      end else begin
         o_data_val <= s1_val;
         if (s1_val)
            edge_q <= s1_border ? '0 : mag_sat;
      end
   end

   assign oRed   = edge_q;
   assign oGreen = edge_q;
   assign oBlue  = edge_q;

endmodule
